// File: rtl/spi_master_if.sv
// spi_master_if: CPU-side register bus of the SPI master (chip select, write strobe, address, data, interrupt)
interface spi_master_if;
  logic       cs_n;
  logic       we_n;
  logic [1:0] rs;
  logic [7:0] din;
  logic [7:0] dout;
  logic       irq_n;
  modport master (output cs_n, we_n, rs, din, input dout, irq_n);
  modport slave (input cs_n, we_n, rs, din, output dout, irq_n);
endinterface

// File: rtl/spi_master.sv
// spi_master: memory-mapped mode-0 MSB-first SPI master with DATA/CTRL/DIV registers and completion interrupt
module spi_master #(
  parameter logic [7:0] DIV_RESET = 8'd3
) (
  input  logic         clk,
  input  logic         reset,
  spi_master_if.slave  bus,
  output logic         spi_sclk,
  output logic         spi_mosi,
  input  logic         spi_miso,
  output logic         spi_ss_n
);
  typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;
  state_t     state_q, state_d;
  logic [7:0] div_q, div_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic [7:0] txsr_q, txsr_d;
  logic [7:0] rxsr_q, rxsr_d;
  logic [7:0] rxdata_q, rxdata_d;
  logic [7:0] dout_q, dout_d;
  logic       ie_q, ie_d;
  logic       ss_q, ss_d;
  logic       done_q, done_d;
  logic       busy_q, busy_d;
  logic       ovr_q, ovr_d;
  logic       sclk_q, sclk_d;
  logic       mosi_q, mosi_d;
  logic       ssn_q, ssn_d;
  logic       wr, rd, half_done;
  logic [7:0] status;
  assign wr        = ~bus.cs_n & ~bus.we_n;
  assign rd        = ~bus.cs_n & bus.we_n;
  assign status    = {done_q, busy_q, ovr_q, 3'b000, ie_q, ss_q};
  assign half_done = cnt_q == div_q;
  assign bus.dout  = dout_q;
  assign bus.irq_n = ~(ie_q & done_q);
  assign spi_sclk  = sclk_q;
  assign spi_mosi  = mosi_q;
  assign spi_ss_n  = ssn_q;
  // State register; reset aborts any transfer in flight without signalling completion
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      div_q    <= DIV_RESET;
      cnt_q    <= 8'h00;
      bitcnt_q <= 3'd0;
      txsr_q   <= 8'h00;
      rxsr_q   <= 8'h00;
      rxdata_q <= 8'h00;
      dout_q   <= 8'h00;
      ie_q     <= 1'b0;
      ss_q     <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      ovr_q    <= 1'b0;
      sclk_q   <= 1'b0;
      mosi_q   <= 1'b0;
      ssn_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      bitcnt_q <= bitcnt_d;
      txsr_q   <= txsr_d;
      rxsr_q   <= rxsr_d;
      rxdata_q <= rxdata_d;
      dout_q   <= dout_d;
      ie_q     <= ie_d;
      ss_q     <= ss_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      ovr_q    <= ovr_d;
      sclk_q   <= sclk_d;
      mosi_q   <= mosi_d;
      ssn_q    <= ssn_d;
    end
  end
  // Register access and transfer sequencing; flag clears by reads come first so same-edge sets win
  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    cnt_d    = cnt_q;
    bitcnt_d = bitcnt_q;
    txsr_d   = txsr_q;
    rxsr_d   = rxsr_q;
    rxdata_d = rxdata_q;
    ie_d     = ie_q;
    ss_d     = ss_q;
    done_d   = done_q;
    busy_d   = busy_q;
    ovr_d    = ovr_q;
    sclk_d   = sclk_q;
    mosi_d   = mosi_q;
    dout_d   = rd ? (bus.rs == 2'd0 ? rxdata_q :
                     bus.rs == 2'd1 ? status :
                     bus.rs == 2'd2 ? div_q : 8'h00) : dout_q;
    if (rd && bus.rs == 2'd0) done_d = 1'b0;
    if (rd && bus.rs == 2'd1) ovr_d = 1'b0;
    if (wr && bus.rs == 2'd1) begin
      ie_d = bus.din[1];
      ss_d = bus.din[0];
    end
    if (wr && bus.rs == 2'd2) div_d = bus.din;
    if (wr && bus.rs == 2'd0 && busy_q) ovr_d = 1'b1;
    if (state_q == IDLE) begin
      if (wr && bus.rs == 2'd0) begin
        txsr_d   = bus.din;
        mosi_d   = bus.din[7];
        cnt_d    = 8'h00;
        bitcnt_d = 3'd0;
        busy_d   = 1'b1;
        done_d   = 1'b0;
        state_d  = LOW;
      end
    end else if (state_q == LOW) begin
      cnt_d = half_done ? 8'h00 : cnt_q + 8'd1;
      if (half_done) begin
        sclk_d  = 1'b1;
        rxsr_d  = {rxsr_q[6:0], spi_miso};
        state_d = HIGH;
      end
    end else begin
      cnt_d = half_done ? 8'h00 : cnt_q + 8'd1;
      if (half_done) begin
        sclk_d = 1'b0;
        if (bitcnt_q == 3'd7) begin
          rxdata_d = rxsr_q;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = IDLE;
        end else begin
          bitcnt_d = bitcnt_q + 3'd1;
          txsr_d   = {txsr_q[6:0], 1'b0};
          mosi_d   = txsr_q[6];
          state_d  = LOW;
        end
      end
    end
    ssn_d = ~ss_d;
  end
endmodule
